// File: rtl/life_datapath.sv
// life_datapath: 8x8 Conway Game of Life board with cell-by-cell pattern entry.
// An external controller selects the mode; this block only holds the board,
// the entry cursor and the combinational next-generation logic.
module life_datapath (
  input  logic        clka,
  input  logic        rst_n,
  input  logic [1:0]  state,
  input  logic        btn0,
  input  logic        btn1,
  input  logic        stop,
  output logic [63:0] grid,
  output logic [5:0]  cursor
);

  typedef enum logic [1:0] {
    MODE_CLEAR = 2'b00,
    MODE_ENTRY = 2'b01,
    MODE_RUN   = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_t;

  logic [63:0] r_grid;
  logic [5:0]  r_cursor;
  logic [63:0] w_nextGen;
  mode_t       w_mode;

  assign w_mode = mode_t'(state);
  assign grid   = r_grid;
  assign cursor = r_cursor;

  // Live neighbours of one cell; positions off the board count as dead, no wrap.
  function automatic logic [3:0] neighborCount(input logic [63:0] board,
                                               input int row,
                                               input int col);
    logic [3:0] sum;
    sum = 4'd0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (!(dr == 0 && dc == 0) &&
            (row + dr) >= 0 && (row + dr) < 8 &&
            (col + dc) >= 0 && (col + dc) < 8) begin
          sum = sum + {3'b000, board[6'((row + dr) * 8 + (col + dc))]};
        end
      end
    end
    return sum;
  endfunction

  // Next generation computed from the whole current board so every cell updates together.
  always_comb begin
    w_nextGen = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        w_nextGen[6'(r * 8 + c)] =
          (neighborCount(r_grid, r, c) == 4'd3) ||
          (r_grid[6'(r * 8 + c)] && (neighborCount(r_grid, r, c) == 4'd2));
      end
    end
  end

  // Board and cursor registers; reset beats every mode, btn0 beats btn1 in entry.
  always_ff @(posedge clka) begin
    if (!rst_n) begin
      r_grid   <= '0;
      r_cursor <= '0;
    end else begin
      case (w_mode)
        MODE_CLEAR: begin
          r_grid   <= '0;
          r_cursor <= '0;
        end
        MODE_ENTRY: begin
          if (btn0) begin
            r_grid[r_cursor] <= 1'b1;
            r_cursor         <= r_cursor + 6'd1;
          end else if (btn1) begin
            r_grid[r_cursor] <= 1'b0;
            r_cursor         <= r_cursor + 6'd1;
          end
        end
        MODE_RUN: begin
          if (!stop) begin
            r_grid <= w_nextGen;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_datapath.sv
// tb_life_datapath: directed vector bench for the Game of Life datapath.
// A table covers reset, clear, entry and the first run steps; hand-written
// sequences cover the multi-cycle patterns and corner cases.
module tb_life_datapath;

  localparam logic [1:0] M_CLEAR = 2'b00;
  localparam logic [1:0] M_ENTRY = 2'b01;
  localparam logic [1:0] M_RUN   = 2'b10;
  localparam logic [1:0] M_HOLD  = 2'b11;

  logic        clka;
  logic        rst_n;
  logic [1:0]  state;
  logic        btn0;
  logic        btn1;
  logic        stop;
  logic [63:0] grid;
  logic [5:0]  cursor;

  int vectorsApplied;
  int miscompares;

  typedef struct {
    string       name;
    logic        rstN;
    logic [1:0]  mode;
    logic        b0;
    logic        b1;
    logic        stp;
    logic [63:0] expGrid;
    logic [5:0]  expCursor;
  } vec_t;

  vec_t vecs[$];

  life_datapath dut (
    .clka   (clka),
    .rst_n  (rst_n),
    .state  (state),
    .btn0   (btn0),
    .btn1   (btn1),
    .stop   (stop),
    .grid   (grid),
    .cursor (cursor)
  );

  // Free-running 10 ns clock.
  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  // Drive inputs on the falling edge, take one rising edge, settle before sampling.
  task automatic applyStimulus(input logic rstN, input logic [1:0] mode,
                               input logic b0, input logic b1, input logic stp);
    @(negedge clka);
    rst_n = rstN;
    state = mode;
    btn0  = b0;
    btn1  = b1;
    stop  = stp;
    @(posedge clka);
    #1;
  endtask

  // Compare board and cursor against the expected values.
  task automatic checkOutput(input string name, input logic [63:0] expGrid,
                             input logic [5:0] expCursor);
    vectorsApplied++;
    if (grid !== expGrid || cursor !== expCursor) begin
      miscompares++;
      $display("[TB] FAIL %s: grid=%h cursor=%0d, expected grid=%h cursor=%0d",
               name, grid, cursor, expGrid, expCursor);
    end
  endtask

  // Clear the board, then write all 64 cells so the cursor wraps back to 0.
  task automatic loadBoard(input string name, input logic [63:0] pattern);
    applyStimulus(1'b1, M_CLEAR, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_clear"}, 64'h0, 6'd0);
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, M_ENTRY, pattern[i], ~pattern[i], 1'b0);
    end
    checkOutput({name, "_load"}, pattern, 6'd0);
  endtask

  function automatic vec_t mkVec(input string name, input logic rstN,
                                 input logic [1:0] mode, input logic b0,
                                 input logic b1, input logic stp,
                                 input logic [63:0] expGrid,
                                 input logic [5:0] expCursor);
    vec_t v;
    v.name = name; v.rstN = rstN; v.mode = mode; v.b0 = b0; v.b1 = b1;
    v.stp = stp; v.expGrid = expGrid; v.expCursor = expCursor;
    return v;
  endfunction

  initial begin
    vectorsApplied = 0;
    miscompares    = 0;
    rst_n = 1'b0;
    state = M_CLEAR;
    btn0  = 1'b0;
    btn1  = 1'b0;
    stop  = 1'b0;

    // Reset, clear, the entry press sequence and the first run step.
    vecs.push_back(mkVec("reset",      1'b0, M_CLEAR, 0, 0, 0, 64'h0,   6'd0));
    vecs.push_back(mkVec("clear",      1'b1, M_CLEAR, 0, 0, 0, 64'h0,   6'd0));
    vecs.push_back(mkVec("entry_b0_a", 1'b1, M_ENTRY, 1, 0, 0, 64'h1,   6'd1));
    vecs.push_back(mkVec("entry_b1_1", 1'b1, M_ENTRY, 0, 1, 0, 64'h1,   6'd2));
    vecs.push_back(mkVec("entry_b1_2", 1'b1, M_ENTRY, 0, 1, 0, 64'h1,   6'd3));
    vecs.push_back(mkVec("entry_b1_3", 1'b1, M_ENTRY, 0, 1, 0, 64'h1,   6'd4));
    vecs.push_back(mkVec("entry_b1_4", 1'b1, M_ENTRY, 0, 1, 0, 64'h1,   6'd5));
    vecs.push_back(mkVec("entry_b1_5", 1'b1, M_ENTRY, 0, 1, 0, 64'h1,   6'd6));
    vecs.push_back(mkVec("entry_b0_b", 1'b1, M_ENTRY, 1, 0, 0, 64'h41,  6'd7));
    vecs.push_back(mkVec("entry_b1_6", 1'b1, M_ENTRY, 0, 1, 0, 64'h41,  6'd8));
    vecs.push_back(mkVec("entry_b0_c", 1'b1, M_ENTRY, 1, 0, 0, 64'h141, 6'd9));
    vecs.push_back(mkVec("entry_b0_d", 1'b1, M_ENTRY, 1, 0, 0, 64'h341, 6'd10));
    vecs.push_back(mkVec("entry_b1_7", 1'b1, M_ENTRY, 0, 1, 0, 64'h341, 6'd11));
    vecs.push_back(mkVec("entry_b1_8", 1'b1, M_ENTRY, 0, 1, 0, 64'h341, 6'd12));
    vecs.push_back(mkVec("entry_idle1",1'b1, M_ENTRY, 0, 0, 0, 64'h341, 6'd12));
    vecs.push_back(mkVec("entry_idle2",1'b1, M_ENTRY, 0, 0, 1, 64'h341, 6'd12));
    vecs.push_back(mkVec("run_first",  1'b1, M_RUN,   0, 0, 0, 64'h303, 6'd12));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rstN, vecs[i].mode, vecs[i].b0, vecs[i].b1, vecs[i].stp);
      checkOutput(vecs[i].name, vecs[i].expGrid, vecs[i].expCursor);
    end

    // The 2x2 block is a still life; buttons are ignored while running.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, M_RUN, 1'b1, 1'b0, 1'b0);
      checkOutput("run_block_stable", 64'h303, 6'd12);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, M_RUN, 1'b0, 1'b1, 1'b1);
      checkOutput("run_block_stopped", 64'h303, 6'd12);
    end

    // Hold ignores both buttons.
    applyStimulus(1'b1, M_HOLD, 1'b1, 1'b0, 1'b0);
    checkOutput("hold_btn0", 64'h303, 6'd12);
    applyStimulus(1'b1, M_HOLD, 1'b0, 1'b1, 1'b0);
    checkOutput("hold_btn1", 64'h303, 6'd12);

    // Blinker oscillates with period two; stop freezes it mid-cycle.
    loadBoard("blinker", 64'h0000_0000_1C00_0000);
    applyStimulus(1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    checkOutput("blinker_gen1", 64'h0000_0008_0808_0000, 6'd0);
    applyStimulus(1'b1, M_RUN, 1'b0, 1'b0, 1'b1);
    checkOutput("blinker_stop", 64'h0000_0008_0808_0000, 6'd0);
    applyStimulus(1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    checkOutput("blinker_gen2", 64'h0000_0000_1C00_0000, 6'd0);

    // Top-row line: off-board neighbours are dead, nothing wraps into row 7.
    loadBoard("edge", 64'h7);
    applyStimulus(1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    checkOutput("edge_gen1", 64'h202, 6'd0);
    vectorsApplied++;
    if (grid[63:56] !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL edge_row7: row7=%h, expected 00", grid[63:56]);
    end

    // Cursor wraps after 64 live writes, leaving a full board.
    applyStimulus(1'b1, M_CLEAR, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap_clear", 64'h0, 6'd0);
    for (int i = 0; i < 63; i++) begin
      applyStimulus(1'b1, M_ENTRY, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("wrap_at63", 64'h7FFF_FFFF_FFFF_FFFF, 6'd63);
    applyStimulus(1'b1, M_ENTRY, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap_to0", 64'hFFFF_FFFF_FFFF_FFFF, 6'd0);

    // Full board: only the four corners (3 neighbours each) survive.
    applyStimulus(1'b1, M_RUN, 1'b0, 1'b0, 1'b0);
    checkOutput("full_board_gen1", 64'h8100_0000_0000_0081, 6'd0);

    // Both buttons together write a live cell.
    applyStimulus(1'b1, M_CLEAR, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, M_ENTRY, 1'b1, 1'b1, 1'b0);
    checkOutput("both_buttons", 64'h1, 6'd1);
    applyStimulus(1'b1, M_ENTRY, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, M_ENTRY, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_entry", 64'h7, 6'd3);

    // Reset while running clears board and cursor on that edge.
    applyStimulus(1'b0, M_RUN, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_in_run", 64'h0, 6'd0);

    // Reset while entering beats a pressed button.
    applyStimulus(1'b1, M_ENTRY, 1'b1, 1'b0, 1'b0);
    checkOutput("entry_after_reset", 64'h1, 6'd1);
    applyStimulus(1'b0, M_ENTRY, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_in_entry", 64'h0, 6'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
